// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared widths and types for the sliding-average datapath
package avg_pkg;
    localparam int SAMPLE_W        = 8;
    localparam int SUM_W           = 11;
    localparam int MAX_WINDOW_LOG2 = 3;
    localparam int FILL_W          = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SUM_W-1:0]    sum_t;
    typedef logic [FILL_W-1:0]   fill_t;
endpackage

// File: rtl/sliding_average_if.sv
// rtl/sliding_average_if.sv - sample stream in, window sum/average out
interface sliding_average_if;
    import avg_pkg::*;

    logic    clear;
    sample_t sample_in;
    logic    sample_valid;
    sum_t    sum_out;
    sample_t avg_out;
    logic    avg_valid;
    fill_t   fill_level;

    modport master (
        output clear, sample_in, sample_valid,
        input  sum_out, avg_out, avg_valid, fill_level
    );

    modport slave (
        input  clear, sample_in, sample_valid,
        output sum_out, avg_out, avg_valid, fill_level
    );
endinterface

// File: rtl/sample_window_buffer.sv
// rtl/sample_window_buffer.sv - circular sample store with write pointer and fill level
module sample_window_buffer
    import avg_pkg::*;
#(
    parameter int WINDOW_LOG2 = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    clear_i,
    input  logic    push_i,
    input  sample_t data_i,
    output sample_t oldest_o,
    output logic    full_o,
    output fill_t   fill_level_o
);
    localparam int DEPTH = 1 << WINDOW_LOG2;
    // A depth-1 window still gets a 1-bit pointer; it simply never leaves slot 0.
    localparam int PTR_W = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
    localparam int SLOTS = 1 << PTR_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam fill_t DEPTH_F = FILL_W'(DEPTH);

    sample_t          buf_q [SLOTS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    fill_t            fill_q, fill_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else if (push_i) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = full_o ? fill_q : fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Contents are never reset; fill level decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            buf_q[wr_ptr_q] <= data_i;
        end
    end

    assign oldest_o     = buf_q[wr_ptr_q];
    assign full_o       = (fill_q == DEPTH_F);
    assign fill_level_o = fill_q;
endmodule

// File: rtl/sliding_average.sv
// rtl/sliding_average.sv - windowed moving average; AVG_ROUND_EN selects round-half-up
module sliding_average
    import avg_pkg::*;
#(
    parameter int WINDOW_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst,
    sliding_average_if.slave bus
);
    generate
        if (WINDOW_LOG2 < 0 || WINDOW_LOG2 > MAX_WINDOW_LOG2) begin : g_bad_window
            $error("sliding_average: WINDOW_LOG2 must be 0..3");
        end
    endgenerate

    localparam fill_t LAST_FILL = FILL_W'((1 << WINDOW_LOG2) - 1);

    sample_t     oldest_raw, oldest;
    logic        full;
    fill_t       fill_level;
    logic [11:0] sum_wide;
    sample_t     avg_next;

    sum_t    sum_q, sum_d;
    sample_t avg_q, avg_d;
    logic    avg_valid_q, avg_valid_d;

    sample_window_buffer #(
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (bus.clear),
        .push_i      (bus.sample_valid),
        .data_i      (bus.sample_in),
        .oldest_o    (oldest_raw),
        .full_o      (full),
        .fill_level_o(fill_level)
    );

    // During warm-up nothing has aged out yet, so nothing is subtracted.
    assign oldest   = full ? oldest_raw : '0;
    assign sum_wide = {1'b0, sum_q} + 12'(bus.sample_in) - 12'(oldest);

`ifdef AVG_ROUND_EN
    localparam logic [11:0] RND = 12'((1 << WINDOW_LOG2) >> 1);
    assign avg_next = sample_t'((sum_wide + RND) >> WINDOW_LOG2);
`else
    assign avg_next = sample_t'(sum_wide >> WINDOW_LOG2);
`endif

    always_comb begin
        sum_d       = sum_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (bus.clear) begin
            sum_d = '0;
            avg_d = '0;
        end else if (bus.sample_valid) begin
            sum_d       = sum_t'(sum_wide);
            avg_d       = avg_next;
            avg_valid_d = full || (fill_level == LAST_FILL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign bus.sum_out    = sum_q;
    assign bus.avg_out    = avg_q;
    assign bus.avg_valid  = avg_valid_q;
    assign bus.fill_level = fill_level;
endmodule

// File: doc/sliding_average.md
# sliding_average

Windowed moving-average engine for the averaging datapath. It accepts a stream of 8-bit samples and keeps a running sum over the last 2^WINDOW_LOG2 samples. On each accepted sample it adds the new value and subtracts the oldest one, then emits the average as the sum right-shifted by WINDOW_LOG2. It is the consuming, subtracting counterpart to the 8+10→11-bit dynamic adder, and it sits between the sample source and the result register bank.

## Interface
Parameters:
- WINDOW_LOG2, default 2: window depth is 2^WINDOW_LOG2 samples. Legal range is 0..3; any other value is a compile-time error.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- clear, input, 1: synchronous flush of the window.
- sample_in, input, 8: unsigned sample.
- sample_valid, input, 1: sample_in is accepted on every cycle where this is high. There is no backpressure.
- sum_out, output, 11: running window sum, unsigned.
- avg_out, output, 8: window average.
- avg_valid, output, 1: one-cycle pulse; avg_out and sum_out are fresh and the window is full.
- fill_level, output, 4: number of samples currently held, 0..2^WINDOW_LOG2.

## Operation
- State:
  - Circular buffer of 2^WINDOW_LOG2 × 8-bit entries.
  - Write pointer wr_ptr, WINDOW_LOG2 bits, wraps modulo depth.
  - fill_level counter.
  - 11-bit sum register.
- Accept (sample_valid=1, clear=0):
  - oldest = buf[wr_ptr] if fill_level == depth, else 0.
  - sum ← sum + sample_in − oldest.
  - buf[wr_ptr] ← sample_in.
  - wr_ptr ← wr_ptr+1, wrapping to 0 after depth−1.
  - fill_level ← min(fill_level+1, depth), saturating.
- Arithmetic:
  - Compute in 12 bits, truncate to 11 bits.
  - The result never exceeds 255·8 = 2040, so no overflow is possible.
- avg_out = sum >> WINDOW_LOG2 (truncating), unless AVG_ROUND_EN is defined (see Configuration).
- avg_valid:
  - Asserted the cycle after an accept whose post-update fill_level equals depth.
  - No pulse during warm-up; the first pulse follows the depth-th sample.
- clear:
  - Sets sum, wr_ptr and fill_level to 0 and suppresses avg_valid.
  - clear and sample_valid in the same cycle: clear wins and the sample is discarded.
  - Buffer contents need not be zeroed, because fill_level gates the oldest-sample read.
- WINDOW_LOG2=0: depth is 1; avg_out = sample and avg_valid follows every accept.
- Idle (sample_valid=0): all state holds, and avg_out/sum_out keep their last values.

## Timing
- Reset values: sum_out=0, avg_out=0, avg_valid=0, fill_level=0, wr_ptr=0.
- Reset asserted mid-stream: the window is abandoned immediately and asynchronously.
- Latency is one cycle: a sample accepted at edge N is reflected in sum_out/avg_out/fill_level after edge N and is valid during cycle N+1.
- avg_out is registered, with no combinational path from sample_in.
- Back-to-back accepts on every cycle are supported at full throughput.

## Configuration
- AVG_ROUND_EN defined:
  - avg_out = (sum + 2^(WINDOW_LOG2−1)) >> WINDOW_LOG2, i.e. round-half-up, computed in 12 bits.
  - Maximum is (2040+4)>>3 = 255, so no saturation is needed.
  - For WINDOW_LOG2=0 there is no rounding term.
- AVG_ROUND_EN undefined: plain truncating shift.
- sum_out is identical in both builds.

## Structure
- Shared package avg_pkg holds:
  - SAMPLE_W=8, SUM_W=11, MAX_WINDOW_LOG2=3.
  - The sample_t and sum_t typedefs.
- One sub-module, sample_window_buffer:
  - Circular storage plus wr_ptr and fill_level.
  - Outputs the oldest entry and a full flag.
  - The top level owns the sum, average and valid logic.

## Test plan
All scenarios use WINDOW_LOG2=2 unless stated.
- Reset, then no samples for 10 cycles → all outputs 0 and no avg_valid pulse.
- Warm-up: samples 3, 13, 27, 59 on consecutive cycles.
  - No avg_valid after the first three.
  - After the fourth: sum_out=102, avg_out=25 (26 with AVG_ROUND_EN), single avg_valid pulse, fill_level=4.
- Wrap: continue from the warm-up state with sample 1 → sum_out=100 (102−3+1), avg_out=25.
  - Then 255, 255, 255 → sum_out=766, avg_out=191 (192 rounded).
- Full scale: four samples of 255 → sum_out=1020, avg_out=255 in both builds.
  - Repeat with WINDOW_LOG2=3 and eight samples of 255 → sum_out=2040, avg_out=255.
- clear together with sample_valid (sample 200) in a full window → next cycle sum_out=0, fill_level=0, no avg_valid.
  - The next four samples of 4 → avg_out=4 with one pulse.
- Asynchronous rst asserted between clock edges mid-stream → outputs go to 0 before the next edge.
  - After release, warm-up restarts and needs 4 fresh samples before avg_valid.
